// File: rtl/test_stream_server_pkg.sv
// rtl/test_stream_server_pkg.sv - shared mode codes and default sizing for the stream server
package test_stream_server_pkg;

  localparam int DEFAULT_DATA_WIDTH = 512;
  localparam int DEFAULT_FIFO_DEPTH = 8;
  localparam int DEFAULT_CNT_WIDTH  = 32;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_INC  = 2'd1,
    MODE_INV  = 2'd2,
    MODE_REV  = 2'd3
  } mode_e;

endpackage

// File: rtl/test_stream_server_fifo.sv
// rtl/test_stream_server_fifo.sv - stream_fifo: output buffer with extra-MSB pointers
module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_areset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             do_pop;
  logic             do_push;

  assign o_empty = (wptr_q == rptr_q);
  assign o_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign o_count = wptr_q - rptr_q;
  assign o_data  = mem_q[rptr_q[AW-1:0]];

  // A push into a full FIFO is accepted when a pop frees the slot in the same cycle.
  assign do_pop  = i_pop & ~o_empty;
  assign do_push = i_push & (~o_full | do_pop);

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/test_stream_server.sv
// rtl/test_stream_server.sv - byte-compacting stream server: compact, transform, buffer, count
module test_stream_server
  import test_stream_server_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_areset,
  input  logic                    i_input_TVALID,
  output logic                    o_input_TREADY,
  input  logic [DATA_WIDTH-1:0]   i_input_TDATA,
  input  logic [DATA_WIDTH/8-1:0] i_input_TKEEP,
  input  logic                    i_input_TLAST,
  output logic                    o_output_TVALID,
  input  logic                    i_output_TREADY,
  output logic [DATA_WIDTH-1:0]   o_output_TDATA,
  output logic [DATA_WIDTH/8-1:0] o_output_TKEEP,
  output logic                    o_output_TLAST,
  input  logic [1:0]              i_mode,
  output logic [CNT_WIDTH-1:0]    o_pkt_count,
  output logic [CNT_WIDTH-1:0]    o_drop_count
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int NW    = $clog2(BYTES) + 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int FW    = DATA_WIDTH + BYTES + 1;

  logic                  ready_q;
  logic                  in_pkt_q;
  mode_e                 pkt_mode_q;
  logic                  s1_valid_q;
  logic [DATA_WIDTH-1:0] s1_data_q;
  logic [NW-1:0]         s1_n_q;
  logic                  s1_last_q;
  mode_e                 s1_mode_q;
  logic                  s2_valid_q;
  logic [DATA_WIDTH-1:0] s2_data_q;
  logic [BYTES-1:0]      s2_keep_q;
  logic                  s2_last_q;
  logic [CNT_WIDTH-1:0]  pkt_cnt_q;
  logic [CNT_WIDTH-1:0]  drop_cnt_q;

  logic                  accept;
  logic                  drop;
  logic                  s1_valid_d;
  logic                  ready_d;
  mode_e                 beat_mode;
  logic [DATA_WIDTH-1:0] s1_data_d;
  logic [NW-1:0]         s1_n_d;
  logic [DATA_WIDTH-1:0] s2_data_d;
  logic [BYTES-1:0]      s2_keep_d;
  int                    occ_d;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [AW:0]           fifo_count;
  logic [FW-1:0]         fifo_rdata;

  assign accept     = i_input_TVALID & ready_q;
  assign drop       = accept & (i_input_TKEEP == '0) & ~i_input_TLAST;
  assign s1_valid_d = accept & ~drop;
  assign beat_mode  = in_pkt_q ? pkt_mode_q : mode_e'(i_mode);

  always_comb begin
    int cnt;
    s1_data_d = '0;
    cnt       = 0;
    for (int i = 0; i < BYTES; i++) begin
      if (i_input_TKEEP[i]) begin
        s1_data_d[cnt*8 +: 8] = i_input_TDATA[i*8 +: 8];
        cnt++;
      end
    end
    s1_n_d = NW'(cnt);
  end

  always_comb begin
    int n;
    s2_data_d = '0;
    s2_keep_d = '0;
    n         = int'(s1_n_q);
    for (int j = 0; j < BYTES; j++) begin
      if (j < n) begin
        s2_keep_d[j] = 1'b1;
        case (s1_mode_q)
          MODE_INC: s2_data_d[j*8 +: 8] = s1_data_q[j*8 +: 8] + 8'd1;
          MODE_INV: s2_data_d[j*8 +: 8] = ~s1_data_q[j*8 +: 8];
          MODE_REV: s2_data_d[j*8 +: 8] = s1_data_q[(n-1-j)*8 +: 8];
          default:  s2_data_d[j*8 +: 8] = s1_data_q[j*8 +: 8];
        endcase
      end
    end
  end

  // Ready counts beats already in flight so every accepted beat is guaranteed a FIFO slot.
  assign fifo_pop  = i_output_TREADY & ~fifo_empty;
  assign fifo_push = s2_valid_q & (~fifo_full | fifo_pop);
  assign occ_d     = int'(fifo_count) + int'(s2_valid_q) - int'(fifo_pop)
                   + int'(s1_valid_q) + int'(s1_valid_d);
  assign ready_d   = occ_d < FIFO_DEPTH;

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      ready_q    <= 1'b0;
      in_pkt_q   <= 1'b0;
      pkt_mode_q <= MODE_PASS;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_n_q     <= '0;
      s1_last_q  <= 1'b0;
      s1_mode_q  <= MODE_PASS;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_keep_q  <= '0;
      s2_last_q  <= 1'b0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      ready_q    <= ready_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s1_valid_q;
      if (accept) begin
        in_pkt_q  <= ~i_input_TLAST;
        s1_data_q <= s1_data_d;
        s1_n_q    <= s1_n_d;
        s1_last_q <= i_input_TLAST;
        s1_mode_q <= beat_mode;
        if (!in_pkt_q) pkt_mode_q <= mode_e'(i_mode);
      end
      if (s1_valid_q) begin
        s2_data_q <= s2_data_d;
        s2_keep_q <= s2_keep_d;
        s2_last_q <= s1_last_q;
      end
      if (fifo_pop && fifo_rdata[FW-1]) pkt_cnt_q <= pkt_cnt_q + 1'b1;
      if (drop) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  stream_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_areset (i_areset),
    .i_push   (fifo_push),
    .i_data   ({s2_last_q, s2_keep_q, s2_data_q}),
    .i_pop    (fifo_pop),
    .o_data   (fifo_rdata),
    .o_full   (fifo_full),
    .o_empty  (fifo_empty),
    .o_count  (fifo_count)
  );

  assign o_input_TREADY  = ready_q;
  assign o_output_TVALID = ~fifo_empty;
  assign {o_output_TLAST, o_output_TKEEP, o_output_TDATA} = fifo_empty ? '0 : fifo_rdata;
  assign o_pkt_count     = pkt_cnt_q;
  assign o_drop_count    = drop_cnt_q;

endmodule

// File: doc/test_stream_server.md
TEST_STREAM_SERVER -- requirements
Module: test_stream_server

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, meaning bus width in bits; legal values are multiples of 8, from 8 to 1024.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning output buffer depth in beats; must be a power of 2 and at least 4.
REQ-003 SHALL have parameter CNT_WIDTH, default 32, meaning the width of the statistics counters.
REQ-004 SHALL have ports: i_clk, in, 1, clock; i_areset, in, 1, reset (one clock; reset is asynchronous and active-high).
REQ-005 SHALL have input-stream ports: i_input_TVALID in 1; o_input_TREADY out 1; i_input_TDATA in DATA_WIDTH; i_input_TKEEP in DATA_WIDTH/8; i_input_TLAST in 1.
REQ-006 SHALL have output-stream ports: o_output_TVALID out 1; i_output_TREADY in 1; o_output_TDATA out DATA_WIDTH; o_output_TKEEP out DATA_WIDTH/8; o_output_TLAST out 1.
REQ-007 SHALL have port i_mode, in, 2, operation select: 0 = pass, 1 = byte increment mod 256, 2 = bitwise invert, 3 = reverse byte order of the compacted bytes.
REQ-008 SHALL have status ports: o_pkt_count out CNT_WIDTH (packets emitted); o_drop_count out CNT_WIDTH (null beats dropped).

Function
REQ-009 Transfer SHALL occur only on a cycle with VALID and READY both high; TREADY SHALL NOT depend combinationally on TVALID.
REQ-010 Each accepted beat SHALL be compacted: kept bytes packed from byte 0 upward in ascending source order, and output TKEEP = 2^n - 1, where n is the number of kept bytes.
REQ-011 Unkept output bytes SHALL be zero.
REQ-012 The operation SHALL apply only to the n kept bytes after compaction.
REQ-013 i_mode SHALL be sampled on the first beat of each packet and held until the beat with TLAST is accepted; changes mid-packet SHALL be ignored.
REQ-014 A beat with TKEEP = 0 and TLAST = 0 SHALL be dropped, and o_drop_count SHALL be incremented.
REQ-015 A beat with TKEEP = 0 and TLAST = 1 SHALL be emitted with TDATA = 0, TKEEP = 0 and TLAST = 1.
REQ-016 Pipeline: stage 1 SHALL register the input and compute the compaction; stage 2 SHALL apply the operation and write the FIFO.
  - Latency from acceptance to o_output_TVALID is 3 cycles when the FIFO is empty.
REQ-017 o_input_TREADY SHALL be high iff (FIFO occupancy + valid pipeline stages) < FIFO_DEPTH, so the pipeline never stalls and no data is lost.
REQ-018 With the FIFO full, a simultaneous pop and push SHALL both succeed, and occupancy SHALL stay unchanged.
REQ-019 With the FIFO empty, o_output_TVALID SHALL be low; a beat SHALL NOT bypass the FIFO.
REQ-020 Once o_output_TVALID is high, TVALID, TDATA, TKEEP and TLAST SHALL hold stable until accepted.
REQ-021 o_pkt_count SHALL increment on each accepted output beat with TLAST = 1.
REQ-022 Both counters SHALL wrap modulo 2^CNT_WIDTH.
REQ-023 FIFO read and write pointers SHALL have log2(FIFO_DEPTH) + 1 bits and wrap naturally; full/empty SHALL be derived from the pointer MSB compare.

Reset
REQ-024 Asserting i_areset SHALL asynchronously clear the FIFO, pipeline valids and mode latch.
  - All outputs go to 0: o_input_TREADY, o_output_TVALID, TDATA, TKEEP, TLAST, and both counters.
REQ-025 o_input_TREADY SHALL rise on the first i_clk edge after reset deassertion.
REQ-026 Reset mid-packet SHALL discard all partial data; the first beat accepted after reset SHALL be treated as the start of a packet.

Structure
REQ-027 A shared package SHALL hold the mode codes (MODE_PASS, MODE_INC, MODE_INV, MODE_REV) and the default width and depth constants.
REQ-028 The FIFO SHALL be a sub-module named stream_fifo, parametrised by width (DATA_WIDTH + DATA_WIDTH/8 + 1) and depth, with push/pop/full/empty/count.

Verification
REQ-029 DATA_WIDTH = 32, mode 0, TDATA = 0xAABBCCDD, TKEEP = 0b1010, TLAST = 1 -> output TDATA = 0x0000AACC, TKEEP = 0b0011, TLAST = 1, pkt_count = 1.
REQ-030 DATA_WIDTH = 32, 3-beat packet, mode = 1 on beat 1, then switched to 2 -> every kept byte +1, and 0xFF becomes 0x00.
REQ-031 Beat with TKEEP = 0, TLAST = 0, then beat with TKEEP = 0, TLAST = 1 -> drop_count = 1, and one output beat with TKEEP = 0, TLAST = 1.
REQ-032 i_output_TREADY = 0 for 20 cycles with continuous input, FIFO_DEPTH = 4 -> TREADY low after 4 beats; no loss or reordering after release; outputs stable while stalled.
REQ-033 Full FIFO with TREADY and TVALID both high every cycle -> throughput of 1 beat per cycle; occupancy constant.
REQ-034 i_areset pulsed mid-packet -> all outputs 0 at once, FIFO empty, and the next packet is processed with the newly sampled i_mode.
